ifm_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single IFM SRAM read port among the per-PE address generators of the fused-block CNN core. Each generator presents a read address with a valid/ready handshake. The arbiter grants one requester per cycle, issues a registered read to memory, tracks which PE owns each in-flight read, and returns the read data with a one-hot response strobe to that PE.

---
 rtl/fbc_mem_pkg.sv | 18 +
 rtl/ifm_read_arbiter_rr_pick.sv | 31 +++
 rtl/ifm_read_arbiter.sv | 132 +++++++++++++
 tb/tb_ifm_read_arbiter.sv | 562 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbc_mem_pkg.sv
// Shared types and constants for the fused-block CNN memory-side blocks
// (IFM read arbiter, address generators).
package fbc_mem_pkg;

  localparam int FBC_ADDR_WIDTH = 32;
  localparam int FBC_DATA_WIDTH = 32;
  localparam int FBC_NUM_REQ    = 16;

  // Index width with a one-bit floor so a single-requester build stays legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FBC_IDX_W = idx_w(FBC_NUM_REQ);

  typedef logic [FBC_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/ifm_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NUM_REQ-1, returned as a one-hot grant and a binary index.
module rr_pick #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ifm_read_arbiter.sv
// Shares the single IFM SRAM read port among the per-PE address generators:
// round-robin grant, registered issue, owner tag pipe, one-hot response strobe.
module ifm_read_arbiter
  import fbc_mem_pkg::*;
#(
  parameter int NUM_REQ    = FBC_NUM_REQ,
  parameter int ADDR_WIDTH = FBC_ADDR_WIDTH,
  parameter int DATA_WIDTH = FBC_DATA_WIDTH,
  parameter int RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                          mem_ready,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [RD_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [IDX_W-1:0]      tag_owner_q [RD_LATENCY];
  logic [IDX_W-1:0]      tag_owner_d [RD_LATENCY];
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  issue_free;
  logic                  grant;
  logic                  accept;
  logic                  tag_exit;
  logic [ADDR_WIDTH-1:0] win_addr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // rst_n gates the grant so req_ready is zero for the whole reset window.
  assign issue_free = !mem_rd_en_q || mem_ready;
  assign grant      = arb_en && issue_free && pick_found && rst_n;
  assign accept     = mem_rd_en_q && mem_ready;
  assign tag_exit   = tag_valid_q[RD_LATENCY-1];

  assign req_ready   = grant ? pick_gnt : '0;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = mem_rd_en_q | (|tag_valid_q);

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_rd_addr_d = mem_rd_addr_q;
    owner_d       = owner_q;
    if (issue_free) begin
      mem_rd_en_d = grant;
      if (grant) begin
        mem_rd_addr_d = win_addr;
        owner_d       = pick_idx;
        rr_ptr_d      = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
      end
    end
  end

  // Tags advance every cycle; memory latency is fixed once a read is accepted.
  always_comb begin
    tag_valid_d[0] = accept;
    tag_owner_d[0] = owner_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_owner_d[k] = tag_owner_q[k-1];
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_exit) begin
      rsp_valid_d = NUM_REQ'(1) << tag_owner_q[RD_LATENCY-1];
      rsp_data_d  = mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      owner_q       <= '0;
      tag_valid_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_owner_q[k] <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      owner_q       <= owner_d;
      tag_valid_q   <= tag_valid_d;
      for (int k = 0; k < RD_LATENCY; k++) tag_owner_q[k] <= tag_owner_d[k];
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ifm_read_arbiter.sv
// Self-checking bench for ifm_read_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level model of the arbiter and SRAM.
module tb_ifm_read_arbiter;

  localparam int NR = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam logic [NR-1:0] ONE = 1;

  logic           clk, rst_n, arb_en, mem_ready, mem_rd_en, busy;
  logic [NR-1:0]  req_valid, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [AW-1:0]  mem_rd_addr;
  logic [DW-1:0]  mem_rd_data, rsp_data;

  int n_checks, n_errors, cyc;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    int            owner;
  } ev_t;

  ev_t mem_q[$];
  ev_t rsp_q[$];

  // Model state: expected issue register, pointer and the winner this cycle.
  bit            m_en;
  logic [AW-1:0] m_addr;
  int            m_owner, m_ptr, m_win;
  logic [DW-1:0] m_last_data;

  logic [NR-1:0] exp_ready, exp_rsp_valid;
  logic          exp_en, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_rsp_data;

  ifm_read_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_ready   (mem_ready),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic model_reset();
    mem_q.delete();
    rsp_q.delete();
    m_en        = 1'b0;
    m_addr      = '0;
    m_owner     = 0;
    m_ptr       = 0;
    m_last_data = '0;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  // Called at a falling edge after inputs are set: drives SRAM data, then
  // derives every expected output for the current cycle.
  task automatic settle();
    int j;
    if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
      mem_rd_data = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      mem_rd_data = $urandom();
    end
    #1;
    exp_en        = m_en;
    exp_addr      = m_addr;
    exp_rsp_valid = '0;
    exp_rsp_data  = m_last_data;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      exp_rsp_valid = ONE << rsp_q[0].owner;
      exp_rsp_data  = rsp_q[0].data;
    end
    exp_busy = m_en;
    foreach (rsp_q[k]) if (rsp_q[k].cyc > cyc) exp_busy = 1'b1;
    m_win = -1;
    if (rst_n && arb_en && (!m_en || mem_ready)) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (req_valid[j]) begin
          m_win = j;
          break;
        end
      end
    end
    exp_ready = (m_win >= 0) ? (ONE << m_win) : '0;
  endtask

  task automatic tick();
    ev_t e;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      m_last_data = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    if (m_en && mem_ready) begin
      e.data  = mem_f(m_addr);
      e.owner = m_owner;
      e.cyc   = cyc + L;
      mem_q.push_back(e);
      e.cyc   = cyc + L + 1;
      rsp_q.push_back(e);
    end
    if (!m_en || mem_ready) begin
      m_en = (m_win >= 0);
      if (m_win >= 0) begin
        m_addr  = req_addr[m_win*AW +: AW];
        m_owner = m_win;
        m_ptr   = (m_win + 1) % NR;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_ready got=%h exp=0", req_ready);
    end
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, busy} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs got en=%b addr=%h rsp=%h data=%h busy=%b exp all 0",
               mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, busy);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc++;
  endtask

  task automatic test_single();
    apply_reset();
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    set_addr(5, 32'h100);
    req_valid = 16'h0020;
    settle();
    n_checks++;
    if (req_ready !== 16'h0020) begin
      n_errors++;
      $display("[TB] FAIL single_grant got=%h exp=0020", req_ready);
    end
    tick();
    req_valid = '0;
    settle();
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h100) begin
      n_errors++;
      $display("[TB] FAIL single_issue got en=%b addr=%h exp en=1 addr=100", mem_rd_en, mem_rd_addr);
    end
    tick();
    settle();
    tick();
    settle();
    n_checks++;
    if (rsp_valid !== '0) begin
      n_errors++;
      $display("[TB] FAIL single_early_rsp got=%h exp=0", rsp_valid);
    end
    tick();
    settle();
    n_checks++;
    if (rsp_valid !== 16'h0020 || rsp_data !== mem_f(32'h100) || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL single_rsp got v=%h d=%h busy=%b exp v=0020 d=%h busy=0",
               rsp_valid, rsp_data, busy, mem_f(32'h100));
    end
    tick();
  endtask

  task automatic test_all_round_robin();
    int cnt[NR];
    int nrsp;
    apply_reset();
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      set_addr(i, $urandom());
      cnt[i] = 0;
    end
    nrsp      = 0;
    req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      if (c == 33) req_valid = '0;
      settle();
      if (c < 33) begin
        n_checks++;
        if (req_ready !== (ONE << (c % NR))) begin
          n_errors++;
          $display("[TB] FAIL rr_order c=%0d got=%h exp=%h", c, req_ready, ONE << (c % NR));
        end
      end
      if (c >= 1 && c <= 33) begin
        n_checks++;
        if (mem_rd_en !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL rr_issue_rate c=%0d got en=%b exp=1", c, mem_rd_en);
        end
      end
      n_checks++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && rsp_data !== exp_rsp_data)) begin
        n_errors++;
        $display("[TB] FAIL rr_rsp c=%0d got v=%h d=%h exp v=%h d=%h",
                 c, rsp_valid, rsp_data, exp_rsp_valid, exp_rsp_data);
      end
      for (int k = 0; k < NR; k++) begin
        if (rsp_valid[k] && nrsp < 32) cnt[k]++;
      end
      if (rsp_valid != '0) nrsp++;
      tick();
    end
    for (int k = 0; k < NR; k++) begin
      n_checks++;
      if (cnt[k] != 2) begin
        n_errors++;
        $display("[TB] FAIL rr_fair req=%0d got=%0d exp=2", k, cnt[k]);
      end
    end
    n_checks++;
    if (nrsp != 33) begin
      n_errors++;
      $display("[TB] FAIL rr_total got=%0d exp=33", nrsp);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] seen [$];
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    a0        = $urandom();
    a1        = $urandom();
    set_addr(2, a0);
    req_valid = 16'h0004;
    settle();
    n_checks++;
    if (req_ready !== 16'h0004) begin
      n_errors++;
      $display("[TB] FAIL bp_grant got=%h exp=0004", req_ready);
    end
    tick();
    set_addr(2, a1);
    mem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      n_checks++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== a0 || req_ready !== '0) begin
        n_errors++;
        $display("[TB] FAIL bp_hold s=%0d got en=%b addr=%h rdy=%h exp en=1 addr=%h rdy=0",
                 s, mem_rd_en, mem_rd_addr, req_ready, a0);
      end
      tick();
    end
    mem_ready = 1'b1;
    settle();
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== a0 || req_ready !== 16'h0004) begin
      n_errors++;
      $display("[TB] FAIL bp_resume got en=%b addr=%h rdy=%h exp en=1 addr=%h rdy=0004",
               mem_rd_en, mem_rd_addr, req_ready, a0);
    end
    tick();
    req_valid = '0;
    settle();
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== a1) begin
      n_errors++;
      $display("[TB] FAIL bp_next got en=%b addr=%h exp en=1 addr=%h", mem_rd_en, mem_rd_addr, a1);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      settle();
      if (rsp_valid != '0) begin
        n_checks++;
        if (rsp_valid !== 16'h0004) begin
          n_errors++;
          $display("[TB] FAIL bp_owner got=%h exp=0004", rsp_valid);
        end
        seen.push_back(rsp_data);
      end
      tick();
    end
    n_checks++;
    if (seen.size() != 2) begin
      n_errors++;
      $display("[TB] FAIL bp_count got=%0d exp=2", seen.size());
    end else begin
      n_checks++;
      if (seen[0] !== mem_f(a0) || seen[1] !== mem_f(a1)) begin
        n_errors++;
        $display("[TB] FAIL bp_data got=%h,%h exp=%h,%h", seen[0], seen[1], mem_f(a0), mem_f(a1));
      end
    end
  endtask

  task automatic test_rr_pointer();
    apply_reset();
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    set_addr(4, $urandom());
    req_valid = 16'h0010;
    settle();
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      settle();
      tick();
    end
    set_addr(3, $urandom());
    set_addr(7, $urandom());
    req_valid = 16'h0088;
    settle();
    n_checks++;
    if (req_ready !== 16'h0080) begin
      n_errors++;
      $display("[TB] FAIL ptr_first got=%h exp=0080", req_ready);
    end
    tick();
    req_valid = 16'h0008;
    settle();
    n_checks++;
    if (req_ready !== 16'h0008) begin
      n_errors++;
      $display("[TB] FAIL ptr_second got=%h exp=0008", req_ready);
    end
    tick();
    req_valid = '1;
    settle();
    n_checks++;
    if (req_ready !== 16'h0010) begin
      n_errors++;
      $display("[TB] FAIL ptr_final got=%h exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if (rsp_valid !== exp_rsp_valid || rsp_data !== exp_rsp_data) begin
        n_errors++;
        $display("[TB] FAIL ptr_rsp got v=%h d=%h exp v=%h d=%h", rsp_valid, rsp_data, exp_rsp_valid, exp_rsp_data);
      end
      tick();
    end
  endtask

  task automatic test_arb_en_drop();
    apply_reset();
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    set_addr(1, $urandom());
    set_addr(2, $urandom());
    req_valid = 16'h0006;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) arb_en = 1'b0;
      settle();
      if (c >= 2) begin
        n_checks++;
        if (req_ready !== '0) begin
          n_errors++;
          $display("[TB] FAIL en_no_grant c=%0d got=%h exp=0", c, req_ready);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (rsp_valid !== 16'h0002 || busy !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL en_rsp1 got v=%h busy=%b exp v=0002 busy=1", rsp_valid, busy);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (rsp_valid !== 16'h0004 || busy !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL en_rsp2 got v=%h busy=%b exp v=0004 busy=0", rsp_valid, busy);
        end
      end
      n_checks++;
      if (rsp_valid !== exp_rsp_valid || busy !== exp_busy) begin
        n_errors++;
        $display("[TB] FAIL en_model c=%0d got v=%h busy=%b exp v=%h busy=%b",
                 c, rsp_valid, busy, exp_rsp_valid, exp_busy);
      end
      tick();
    end
    req_valid = '0;
    arb_en    = 1'b1;
  endtask

  task automatic test_reset_midflight();
    arb_en    = 1'b1;
    mem_ready = 1'b1;
    set_addr(1, $urandom());
    set_addr(2, $urandom());
    req_valid = 16'h0006;
    settle();
    tick();
    settle();
    tick();
    settle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, busy} !== '0) begin
      n_errors++;
      $display("[TB] FAIL midreset_outputs got rdy=%h en=%b addr=%h rsp=%h data=%h busy=%b exp all 0",
               req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, busy);
    end
    model_reset();
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL midreset_stale c=%0d got v=%h busy=%b exp v=0 busy=0", c, rsp_valid, busy);
      end
      tick();
    end
    set_addr(9, $urandom());
    set_addr(12, $urandom());
    req_valid = 16'h1200;
    settle();
    n_checks++;
    if (req_ready !== 16'h0200) begin
      n_errors++;
      $display("[TB] FAIL midreset_first got=%h exp=0200", req_ready);
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      settle();
      tick();
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] last_gnt;
    last_gnt = '0;
    for (int c = 0; c < 600; c++) begin
      arb_en    = ($urandom_range(0, 9) != 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NR; i++) begin
        if (last_gnt[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            set_addr(i, $urandom());
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (c >= 590) begin
        req_valid = '0;
        mem_ready = 1'b1;
      end
      settle();
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_errors++;
        $display("[TB] FAIL rand_ready c=%0d got=%h exp=%h", c, req_ready, exp_ready);
      end
      n_checks++;
      if (mem_rd_en !== exp_en || (exp_en && mem_rd_addr !== exp_addr)) begin
        n_errors++;
        $display("[TB] FAIL rand_issue c=%0d got en=%b addr=%h exp en=%b addr=%h",
                 c, mem_rd_en, mem_rd_addr, exp_en, exp_addr);
      end
      n_checks++;
      if (rsp_valid !== exp_rsp_valid || rsp_data !== exp_rsp_data) begin
        n_errors++;
        $display("[TB] FAIL rand_rsp c=%0d got v=%h d=%h exp v=%h d=%h",
                 c, rsp_valid, rsp_data, exp_rsp_valid, exp_rsp_data);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("[TB] FAIL rand_busy c=%0d got=%b exp=%b", c, busy, exp_busy);
      end
      last_gnt = exp_ready;
      tick();
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    arb_en      = 1'b0;
    mem_ready   = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    mem_rd_data = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_round_robin();
    test_backpressure();
    test_rr_pointer();
    test_arb_en_drop();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
